// File: rtl/phy_init_sequencer.sv
// PHY bring-up sequencer: hardware reset, settle delay, register
// table writes over MDIO, then periodic BMSR link-status polling.
module phy_init_sequencer #(
  parameter int unsigned RESET_CYCLES      = 1250000,
  parameter int unsigned POST_RESET_CYCLES = 625000,
  parameter int unsigned POLL_CYCLES       = 125000,
  parameter int unsigned ACK_TIMEOUT       = 4096,
  parameter int unsigned NUM_CFG           = 2,
  parameter logic [21*NUM_CFG-1:0] CFG_TABLE =
    {21'h04_01E1, 21'h00_1140}
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  output logic        phy_resetn,
  output logic        mdio_req,
  output logic        mdio_wr,
  output logic [4:0]  mdio_reg,
  output logic [15:0] mdio_wdata,
  input  logic        mdio_ack,
  input  logic [15:0] mdio_rdata,
  output logic        init_done,
  output logic        link_up,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    CFG,
    POLL_IDLE,
    POLL_RD
  } state_t;

  localparam logic [23:0] RST_N  = 24'(RESET_CYCLES);
  localparam logic [23:0] POST_N = 24'(POST_RESET_CYCLES);
  localparam logic [23:0] POLL_N = 24'(POLL_CYCLES);
  localparam logic [23:0] ACK_N  = 24'(ACK_TIMEOUT);
  localparam logic [3:0]  LAST   = 4'(NUM_CFG - 1);

  state_t      state;
  logic [23:0] cnt;
  logic [3:0]  idx;
  logic [20:0] entry;

  assign entry = CFG_TABLE[21*idx +: 21];

  // cnt==0 in RST_HOLD only occurs straight out of async reset;
  // that first edge already counts as one reset cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RST_HOLD;
      cnt         <= '0;
      idx         <= '0;
      phy_resetn  <= 1'b0;
      mdio_req    <= 1'b0;
      mdio_wr     <= 1'b0;
      mdio_reg    <= '0;
      mdio_wdata  <= '0;
      init_done   <= 1'b0;
      link_up     <= 1'b0;
      err_timeout <= 1'b0;
    end else if (restart) begin
      state       <= RST_HOLD;
      cnt         <= RST_N;
      idx         <= '0;
      phy_resetn  <= 1'b0;
      mdio_req    <= 1'b0;
      mdio_wr     <= 1'b0;
      mdio_reg    <= '0;
      mdio_wdata  <= '0;
      init_done   <= 1'b0;
      link_up     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      unique case (state)
        RST_HOLD: begin
          if (cnt == 24'd1 || (cnt == '0 && RST_N == 24'd1)) begin
            phy_resetn <= 1'b1;
            state      <= RST_WAIT;
            cnt        <= POST_N;
          end else if (cnt == '0) begin
            cnt <= RST_N - 24'd1;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        RST_WAIT: begin
          if (cnt == 24'd1) begin
            state      <= CFG;
            idx        <= '0;
            mdio_req   <= 1'b1;
            mdio_wr    <= 1'b1;
            mdio_reg   <= CFG_TABLE[20:16];
            mdio_wdata <= CFG_TABLE[15:0];
            cnt        <= ACK_N;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        CFG: begin
          if (!mdio_req) begin
            mdio_req   <= 1'b1;
            mdio_wr    <= 1'b1;
            mdio_reg   <= entry[20:16];
            mdio_wdata <= entry[15:0];
            cnt        <= ACK_N;
          end else if (mdio_ack) begin
            mdio_req <= 1'b0;
            if (idx == LAST) begin
              init_done <= 1'b1;
              state     <= POLL_IDLE;
              cnt       <= POLL_N;
            end else begin
              idx <= idx + 4'd1;
            end
          end else if (cnt == 24'd1) begin
            err_timeout <= 1'b1;
            init_done   <= 1'b0;
            link_up     <= 1'b0;
            mdio_req    <= 1'b0;
            phy_resetn  <= 1'b0;
            idx         <= '0;
            state       <= RST_HOLD;
            cnt         <= RST_N;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        POLL_IDLE: begin
          if (cnt == 24'd1) begin
            state      <= POLL_RD;
            mdio_req   <= 1'b1;
            mdio_wr    <= 1'b0;
            mdio_reg   <= 5'd1;
            mdio_wdata <= '0;
            cnt        <= ACK_N;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        POLL_RD: begin
          if (mdio_ack) begin
            link_up  <= mdio_rdata[2];
            mdio_req <= 1'b0;
            state    <= POLL_IDLE;
            cnt      <= POLL_N;
          end else if (cnt == 24'd1) begin
            err_timeout <= 1'b1;
            init_done   <= 1'b0;
            link_up     <= 1'b0;
            mdio_req    <= 1'b0;
            phy_resetn  <= 1'b0;
            idx         <= '0;
            state       <= RST_HOLD;
            cnt         <= RST_N;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        default: state <= RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_init_sequencer.sv
// Randomized bench for phy_init_sequencer: MDIO responder with random
// ack latency, checked against edge-count expectations.
module tb_phy_init_sequencer;

  localparam int R = 8;
  localparam int P = 4;
  localparam int Q = 16;
  localparam int T = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        restart = 1'b0;
  logic        phy_resetn;
  logic        mdio_req;
  logic        mdio_wr;
  logic [4:0]  mdio_reg;
  logic [15:0] mdio_wdata;
  logic        mdio_ack = 1'b0;
  logic [15:0] mdio_rdata = '0;
  logic        init_done;
  logic        link_up;
  logic        err_timeout;

  int total = 0;
  int bad = 0;
  logic exp_link = 1'b0;

  logic [4:0]  tbl_reg [2] = '{5'h00, 5'h04};
  logic [15:0] tbl_dat [2] = '{16'h1140, 16'h01E1};

  phy_init_sequencer #(
    .RESET_CYCLES(R),
    .POST_RESET_CYCLES(P),
    .POLL_CYCLES(Q),
    .ACK_TIMEOUT(T),
    .NUM_CFG(2),
    .CFG_TABLE({21'h04_01E1, 21'h00_1140})
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .restart(restart),
    .phy_resetn(phy_resetn),
    .mdio_req(mdio_req),
    .mdio_wr(mdio_wr),
    .mdio_reg(mdio_reg),
    .mdio_wdata(mdio_wdata),
    .mdio_ack(mdio_ack),
    .mdio_rdata(mdio_rdata),
    .init_done(init_done),
    .link_up(link_up),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {6'd0, phy_resetn, mdio_req, mdio_wr, mdio_reg,
            mdio_wdata, init_done, link_up, err_timeout};
  endfunction

  task automatic expect_phy(input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk("phy_resetn", 32'(phy_resetn), 32'(i == n));
    end
  endtask

  // req low for n-1 edges, rises at edge n; stray acks must be ignored
  task automatic expect_rise(input string tag, input int n,
                             input bit noise);
    for (int i = 1; i <= n; i++) begin
      if (noise) begin
        mdio_ack   = 1'($urandom);
        mdio_rdata = 16'($urandom);
      end
      tick();
      mdio_ack = 1'b0;
      chk(tag, 32'(mdio_req), 32'(i == n));
      if (noise) chk("link_hold", 32'(link_up), 32'(exp_link));
    end
  endtask

  task automatic serve(input int d, input logic [15:0] rd,
                       input logic wr, input logic [4:0] rg,
                       input logic [15:0] dat);
    logic [31:0] want;
    want = {9'd0, 1'b1, wr, rg, dat};
    chk("req_fields", {9'd0, mdio_req, mdio_wr, mdio_reg, mdio_wdata}, want);
    for (int i = 1; i < d; i++) begin
      tick();
      chk("req_stable", {9'd0, mdio_req, mdio_wr, mdio_reg, mdio_wdata},
          want);
    end
    mdio_ack   = 1'b1;
    mdio_rdata = rd;
    tick();
    mdio_ack = 1'b0;
    chk("req_drop", 32'(mdio_req), 32'd0);
  endtask

  task automatic power_on();
    expect_phy(R);
    expect_rise("first_req", P, 1'b0);
  endtask

  task automatic config_seq();
    for (int j = 0; j < 2; j++) begin
      if (j > 0) expect_rise("cfg_gap", 1, 1'b0);
      serve(int'($urandom_range(1, 12)), 16'($urandom), 1'b1,
            tbl_reg[j], tbl_dat[j]);
      chk("init_done", 32'(init_done), 32'(j == 1));
    end
  endtask

  task automatic poll(input logic [15:0] rd);
    expect_rise("poll_req", Q, 1'b1);
    serve(int'($urandom_range(1, 20)), rd, 1'b0, 5'd1, 16'd0);
    exp_link = rd[2];
    chk("link_up", 32'(link_up), 32'(exp_link));
  endtask

  initial begin
    #12;
    chk("reset_outs", all_outs(), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_outs2", all_outs(), 32'd0);
    reset_n = 1'b1;

    power_on();
    config_seq();
    exp_link = 1'b0;
    poll(16'h0004);
    poll(16'h0000);
    for (int k = 0; k < 3; k++) poll(16'($urandom));
    poll(16'hFFFB);

    // restart together with a poll ack
    expect_rise("poll_req", Q, 1'b1);
    restart    = 1'b1;
    mdio_ack   = 1'b1;
    mdio_rdata = 16'h0004;
    tick();
    restart  = 1'b0;
    mdio_ack = 1'b0;
    exp_link = 1'b0;
    chk("rs_link", 32'(link_up), 32'd0);
    chk("rs_outs", {29'd0, phy_resetn, mdio_req, init_done},
        32'd0);
    chk("rs_err", 32'(err_timeout), 32'd0);

    // full re-init, then no ack on the first write
    power_on();
    for (int i = 1; i <= T; i++) begin
      tick();
      chk("err_timeout", 32'(err_timeout), 32'(i == T));
    end
    chk("to_outs", {28'd0, phy_resetn, mdio_req, init_done, link_up},
        32'd0);
    expect_phy(R);
    expect_rise("first_req", P, 1'b0);
    config_seq();
    chk("err_sticky", 32'(err_timeout), 32'd1);
    poll(16'h0004);

    // async reset between edges during config
    expect_phy(0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    power_on();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_outs", all_outs(), 32'd0);
    tick();
    reset_n = 1'b1;
    exp_link = 1'b0;
    power_on();
    config_seq();
    poll(16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
